// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: request ops, memory mux selects, FSM states, exception codes.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } lsu_op_e;

  localparam logic [1:0] S_MUX_WORD = 2'b00;
  localparam logic [1:0] S_MUX_HALF = 2'b01;
  localparam logic [1:0] S_MUX_BYTE = 2'b10;

  localparam logic [2:0] L_MUX_LW  = 3'b000;
  localparam logic [2:0] L_MUX_LH  = 3'b001;
  localparam logic [2:0] L_MUX_LHU = 3'b010;
  localparam logic [2:0] L_MUX_LB  = 3'b011;
  localparam logic [2:0] L_MUX_LBU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic op_is_store(input lsu_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Stores only; loads leave the store mux at its idle value.
  function automatic logic [1:0] op_s_mux(input lsu_op_e op);
    case (op)
      OP_SH:   return S_MUX_HALF;
      OP_SB:   return S_MUX_BYTE;
      default: return S_MUX_WORD;
    endcase
  endfunction

  // Loads only; stores leave the load mux at its idle value.
  function automatic logic [2:0] op_l_mux(input lsu_op_e op);
    case (op)
      OP_LH:   return L_MUX_LH;
      OP_LHU:  return L_MUX_LHU;
      OP_LB:   return L_MUX_LB;
      OP_LBU:  return L_MUX_LBU;
      default: return L_MUX_LW;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Address checker: alignment and data-memory window test for one request, plus window offset.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever the requester presents.
// Ports: op/addr in; fault (address error), exc_code (AdEL/AdES or 0), offset (addr - DMEM_BASE) out.
module lsu_addr_check
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  lsu_op_e     op,
  input  logic [31:0] addr,
  output logic        fault,
  output logic [4:0]  exc_code,
  output logic [31:0] offset
);

  localparam logic [31:0] WINDOW_BYTES = 32'(DMEM_BYTES);

  logic misaligned;
  logic out_of_window;

  // Modulo-2^32 subtraction: addresses below the base wrap high and land outside the window.
  assign offset = addr - DMEM_BASE;
  assign out_of_window = (offset >= WINDOW_BYTES);

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign fault    = misaligned || out_of_window;
  assign exc_code = !fault ? 5'd0 : (op_is_store(op) ? EXC_ADES : EXC_ADEL);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU memory request, drives the data memory for one cycle, returns a response pulse.
// Latency: legal access responds 2 cycles after acceptance, faulting access 1 cycle; one request per 3 cycles.
// Backpressure: req_ready high only in IDLE; requester holds req_valid until accepted.
// Ports: clk/rst; req_* request channel; resp_*/badvaddr response; dmem_* synchronous data-memory port.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic [31:0] badvaddr,
  output logic        dmem_wena,
  output logic [1:0]  dmem_s_mux,
  output logic [2:0]  dmem_l_mux,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state;
  lsu_op_e     op_q;
  lsu_op_e     req_op_e;
  logic        fault;
  logic [4:0]  exc_code;
  logic [31:0] offset;

  assign req_op_e  = lsu_op_e'(req_op);
  assign req_ready = (state == ST_IDLE);

  lsu_addr_check #(
    .DMEM_BASE  (DMEM_BASE),
    .DMEM_BYTES (DMEM_BYTES)
  ) u_addr_check (
    .op       (req_op_e),
    .addr     (req_addr),
    .fault    (fault),
    .exc_code (exc_code),
    .offset   (offset)
  );

  // The dmem_* outputs are registers loaded at acceptance and cleared leaving ACCESS,
  // so they are non-zero only during ACCESS and reset drops them (notably wena) at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      op_q          <= OP_LW;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= 1'b0;
      resp_exc_code <= '0;
      badvaddr      <= '0;
      dmem_wena     <= 1'b0;
      dmem_s_mux    <= S_MUX_WORD;
      dmem_l_mux    <= L_MUX_LW;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q <= req_op_e;
            if (fault) begin
              // Memory is never touched; the response carries the exception immediately.
              state         <= ST_RESP;
              resp_valid    <= 1'b1;
              resp_rdata    <= '0;
              resp_exc      <= 1'b1;
              resp_exc_code <= exc_code;
              badvaddr      <= req_addr;
            end else begin
              state      <= ST_ACCESS;
              dmem_wena  <= op_is_store(req_op_e);
              dmem_s_mux <= op_s_mux(req_op_e);
              dmem_l_mux <= op_l_mux(req_op_e);
              dmem_addr  <= offset;
              dmem_wdata <= req_wdata;
            end
          end
        end
        ST_ACCESS: begin
          state         <= ST_RESP;
          resp_valid    <= 1'b1;
          resp_rdata    <= op_is_store(op_q) ? 32'd0 : dmem_rdata;
          resp_exc      <= 1'b0;
          resp_exc_code <= '0;
          badvaddr      <= '0;
          dmem_wena     <= 1'b0;
          dmem_s_mux    <= S_MUX_WORD;
          dmem_l_mux    <= L_MUX_LW;
          dmem_addr     <= '0;
          dmem_wdata    <= '0;
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed data-memory model.
// Latency: observes response timing relative to the acceptance edge.
// Backpressure: drives one request at a time except for the held-valid streaming step.
module tb_load_store_unit;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LHU = 3'b010;
  localparam logic [2:0] LB  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] SW  = 3'b101;
  localparam logic [2:0] SB  = 3'b111;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic [31:0] badvaddr;
  logic        dmem_wena;
  logic [1:0]  dmem_s_mux;
  logic [2:0]  dmem_l_mux;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  int n_assert;
  int n_fail;
  int wr_count;
  int wr_snap;
  logic mem_clr;

  logic [7:0]  mem [4096];
  logic [11:0] ra0, ra1, ra2, ra3;

  load_store_unit dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_exc      (resp_exc),
    .resp_exc_code (resp_exc_code),
    .badvaddr      (badvaddr),
    .dmem_wena     (dmem_wena),
    .dmem_s_mux    (dmem_s_mux),
    .dmem_l_mux    (dmem_l_mux),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory: writes on negedge, combinational extended reads.
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (dmem_wena) begin
      wr_count <= wr_count + 1;
      case (dmem_s_mux)
        2'b00: begin
          mem[ra0] <= dmem_wdata[7:0];
          mem[ra1] <= dmem_wdata[15:8];
          mem[ra2] <= dmem_wdata[23:16];
          mem[ra3] <= dmem_wdata[31:24];
        end
        2'b01: begin
          mem[ra0] <= dmem_wdata[7:0];
          mem[ra1] <= dmem_wdata[15:8];
        end
        default: mem[ra0] <= dmem_wdata[7:0];
      endcase
    end
  end

  assign ra0 = dmem_addr[11:0];
  assign ra1 = ra0 + 12'd1;
  assign ra2 = ra0 + 12'd2;
  assign ra3 = ra0 + 12'd3;

  always_comb begin
    dmem_rdata = 32'h0;
    case (dmem_l_mux)
      3'b000: dmem_rdata = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
      3'b001: dmem_rdata = {{16{mem[ra1][7]}}, mem[ra1], mem[ra0]};
      3'b010: dmem_rdata = {16'h0, mem[ra1], mem[ra0]};
      3'b011: dmem_rdata = {{24{mem[ra0][7]}}, mem[ra0]};
      3'b100: dmem_rdata = {24'h0, mem[ra0]};
      default: dmem_rdata = 32'h0;
    endcase
    if (dmem_addr[31:12] != 20'h0) dmem_rdata = 32'hBAD0_BAD0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request while idle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for the response, checks its latency and fields, then its one-cycle width.
  task automatic finish_resp(input string tag, input int exp_lat, input logic exp_exc,
                             input logic [4:0] exp_code, input logic [31:0] exp_rdata,
                             input logic [31:0] exp_bad);
    int lat;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 5) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " req_ready in RESP"}, 32'(req_ready), 32'd0);
    check({tag, " resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, " resp_exc"}, 32'(resp_exc), 32'(exp_exc));
    check({tag, " resp_exc_code"}, 32'(resp_exc_code), 32'(exp_code));
    check({tag, " badvaddr"}, badvaddr, exp_bad);
    step();
    check({tag, " pulse ends"}, 32'(resp_valid), 32'd0);
    check({tag, " ready again"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_access(input string tag, input logic wena, input logic [1:0] smux,
                              input logic [2:0] lmux, input logic [31:0] addr);
    check({tag, " req_ready"}, 32'(req_ready), 32'd0);
    check({tag, " dmem_wena"}, 32'(dmem_wena), 32'(wena));
    check({tag, " dmem_s_mux"}, 32'(dmem_s_mux), 32'(smux));
    check({tag, " dmem_l_mux"}, 32'(dmem_l_mux), 32'(lmux));
    check({tag, " dmem_addr"}, dmem_addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    wr_count  = 0;
    mem_clr   = 1'b1;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = LW;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_exc", 32'(resp_exc), 32'd0);
    check("reset resp_exc_code", 32'(resp_exc_code), 32'd0);
    check("reset badvaddr", badvaddr, 32'd0);
    check("reset dmem_wena", 32'(dmem_wena), 32'd0);
    check("reset dmem_addr", dmem_addr, 32'd0);
    check("reset dmem_wdata", dmem_wdata, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    mem_clr = 1'b0;
    step();

    // Word store then load at offset 8.
    issue(SW, 32'h1001_0008, 32'hDEAD_BEEF);
    check_access("SW", 1'b1, 2'b00, 3'b000, 32'h0000_0008);
    check("SW dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("SW resp_valid in ACCESS", 32'(resp_valid), 32'd0);
    finish_resp("SW", 2, 1'b0, 5'd0, 32'h0, 32'h0);
    issue(LW, 32'h1001_0008, 32'h0);
    check_access("LW", 1'b0, 2'b00, 3'b000, 32'h0000_0008);
    finish_resp("LW", 2, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0);
    issue(LH, 32'h1001_0008, 32'h0);
    finish_resp("LH", 2, 1'b0, 5'd0, 32'hFFFF_BEEF, 32'h0);
    issue(LHU, 32'h1001_0008, 32'h0);
    finish_resp("LHU", 2, 1'b0, 5'd0, 32'h0000_BEEF, 32'h0);

    // Byte store and sign/zero extended byte loads.
    issue(SB, 32'h1001_0003, 32'h0000_0080);
    check_access("SB", 1'b1, 2'b10, 3'b000, 32'h0000_0003);
    finish_resp("SB", 2, 1'b0, 5'd0, 32'h0, 32'h0);
    issue(LB, 32'h1001_0003, 32'h0);
    check_access("LB", 1'b0, 2'b00, 3'b011, 32'h0000_0003);
    finish_resp("LB", 2, 1'b0, 5'd0, 32'hFFFF_FF80, 32'h0);
    issue(LBU, 32'h1001_0003, 32'h0);
    check_access("LBU", 1'b0, 2'b00, 3'b100, 32'h0000_0003);
    finish_resp("LBU", 2, 1'b0, 5'd0, 32'h0000_0080, 32'h0);

    // Last legal word of the window.
    issue(SW, 32'h1001_0FFC, 32'h1234_5678);
    finish_resp("SW last", 2, 1'b0, 5'd0, 32'h0, 32'h0);
    issue(LW, 32'h1001_0FFC, 32'h0);
    finish_resp("LW last", 2, 1'b0, 5'd0, 32'h1234_5678, 32'h0);

    // Faulting requests: memory must stay idle.
    wr_snap = wr_count;
    issue(LH, 32'h1001_0001, 32'h0);
    check("misaligned LH dmem_wena", 32'(dmem_wena), 32'd0);
    check("misaligned LH dmem_l_mux", 32'(dmem_l_mux), 32'd0);
    finish_resp("misaligned LH", 1, 1'b1, 5'd4, 32'h0, 32'h1001_0001);
    issue(SW, 32'h1001_1000, 32'h5555_5555);
    finish_resp("SW past window", 1, 1'b1, 5'd5, 32'h0, 32'h1001_1000);
    issue(SW, 32'h1000_FFFC, 32'h6666_6666);
    finish_resp("SW below base", 1, 1'b1, 5'd5, 32'h0, 32'h1000_FFFC);
    check("faults wrote nothing", 32'(wr_count), 32'(wr_snap));

    // Held req_valid: accepted every third cycle.
    req_op    = LW;
    req_addr  = 32'h1001_0008;
    req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("stream req_ready t%0d", i), 32'(req_ready), 32'((i % 3) == 0));
      check($sformatf("stream resp_valid t%0d", i), 32'(resp_valid), 32'((i % 3) == 2));
      if ((i % 3) == 2) check($sformatf("stream rdata t%0d", i), resp_rdata, 32'hDEAD_BEEF);
      if (i == 8) req_valid = 1'b0;
      step();
    end
    check("stream idle after", 32'(req_ready), 32'd1);

    // Reset in the middle of a store's ACCESS cycle, before its negedge.
    wr_snap = wr_count;
    issue(SW, 32'h1001_0010, 32'hCAFE_F00D);
    check("rst-SW dmem_wena before", 32'(dmem_wena), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst-SW dmem_wena", 32'(dmem_wena), 32'd0);
    check("rst-SW dmem_addr", dmem_addr, 32'd0);
    check("rst-SW dmem_wdata", dmem_wdata, 32'd0);
    check("rst-SW req_ready", 32'(req_ready), 32'd1);
    check("rst-SW resp_valid", 32'(resp_valid), 32'd0);
    check("rst-SW resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst-SW no resp c%0d", i), 32'(resp_valid), 32'd0);
    end
    check("rst-SW store lost", 32'(wr_count), 32'(wr_snap));
    issue(LW, 32'h1001_0010, 32'h0);
    finish_resp("LW after reset", 2, 1'b0, 5'd0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: DMEM_BASE, 32'h1001_0000, byte address of data-memory offset 0; DMEM_BYTES, 4096, size of the data-memory window in bytes.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  CPU memory request present.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 req_addr  in  32  effective byte address.
REQ-008 req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
REQ-009 resp_valid  out  1  one-cycle completion pulse.
REQ-010 resp_rdata  out  32  extended load result; 0 for stores and exceptions.
REQ-011 resp_exc  out  1  address-error exception flag, valid with resp_valid.
REQ-012 resp_exc_code  out  5  4 (AdEL) for loads, 5 (AdES) for stores; 0 when resp_exc=0.
REQ-013 badvaddr  out  32  faulting req_addr, valid with resp_exc.
REQ-014 dmem_wena  out  1  data-memory write enable.
REQ-015 dmem_s_mux  out  2  00 word, 01 half, 10 byte.
REQ-016 dmem_l_mux  out  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu.
REQ-017 dmem_addr  out  32  req_addr minus DMEM_BASE.
REQ-018 dmem_wdata  out  32  store data passed unchanged.
REQ-019 dmem_rdata  in  32  combinational data-memory read result, already extended.

Function
REQ-020 FSM SHALL have states IDLE, ACCESS, RESP; req_ready SHALL equal (state==IDLE).
REQ-021 Handshake: request accepted on posedge where req_valid&&req_ready; op, addr, wdata captured into registers.
REQ-022 Exception check at acceptance: LW/SW need addr[1:0]==0, LH/LHU/SH need addr[0]==0; any access with (addr-DMEM_BASE) unsigned >= DMEM_BYTES also faults.
REQ-023 Legal request: IDLE->ACCESS; faulting request: IDLE->RESP directly, memory never driven.
REQ-024 ACCESS lasts exactly one cycle, then ->RESP; RESP lasts one cycle, then ->IDLE.
REQ-025 In ACCESS dmem_addr, dmem_wdata, dmem_s_mux, dmem_l_mux SHALL be driven from registered fields and dmem_wena=1 only for stores, so the memory's negedge write occurs mid-ACCESS.
REQ-026 Loads: dmem_rdata SHALL be registered into resp_rdata at the posedge leaving ACCESS.
REQ-027 Outside ACCESS: dmem_wena=0, dmem_l_mux=000, dmem_s_mux=00, dmem_addr=0.
REQ-028 resp_valid=1 only in RESP; resp_rdata, resp_exc, resp_exc_code, badvaddr held stable through RESP and until next response.
REQ-029 Latency: legal access accepted at edge k, resp_valid high cycle k+2; faulting access resp_valid high cycle k+1; throughput one request per 3 cycles (legal).
REQ-030 req_valid while not ready SHALL be ignored; requester holds it.
REQ-031 Address arithmetic SHALL be 32-bit unsigned modulo 2^32; addresses below DMEM_BASE wrap to large values and fault.

Reset
REQ-032 rst asserted SHALL immediately force state=IDLE, req_ready=1, resp_valid=0, resp_exc=0, resp_exc_code=0, resp_rdata=0, badvaddr=0, and all dmem_* outputs to 0.
REQ-033 Reset during ACCESS SHALL drop dmem_wena asynchronously; a store whose negedge had not yet occurred is lost, no response is produced.

Structure
REQ-034 Shared package SHALL hold the req_op encodings, s_mux/l_mux encodings, state encoding and exception codes 4/5.
REQ-035 One sub-module lsu_addr_check (combinational: op, addr -> fault, exc_code, offset) is natural; the FSM stays in the top.

Verification
REQ-036 SW addr 0x10010008 data 0xDEADBEEF then LW same -> ACCESS wena=1 s_mux=00 dmem_addr=0x8; load resp_rdata=0xDEADBEEF at k+2, resp_exc=0.
REQ-037 SB 0x80 to 0x10010003 then LB and LBU same -> l_mux 011 gives 0xFFFFFF80, l_mux 100 gives 0x00000080.
REQ-038 LH addr 0x10010001 -> resp at k+1, resp_exc=1, code=4, badvaddr=0x10010001, dmem_wena never 1.
REQ-039 SW addr 0x10011000 (offset = DMEM_BYTES) and SW 0x1000FFFC -> both faulting, code=5, no write.
REQ-040 Back-to-back req_valid held high -> accepts every 3rd cycle, req_ready low in ACCESS/RESP, each response pulse exactly one cycle.
REQ-041 rst asserted mid-ACCESS of SW -> all outputs 0 within the same cycle, no resp_valid, next request accepted normally after release.
